// File: rtl/serial_parity_pkg.sv
// Shared types and defaults for the serial parity transmitter.
package serial_parity_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

endpackage

// File: rtl/serial_parity_tx_parity_accum.sv
// Running-parity flop: clear has priority, otherwise XOR in bit_in when enabled.
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic parity
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (clr) begin
            parity <= 1'b0;
        end else if (en) begin
            parity <= parity ^ bit_in;
        end
    end

endmodule

// File: rtl/serial_parity_tx.sv
// Parallel-to-serial transmitter: WIDTH data bits LSB first, then one parity beat.
// Optional busy output enabled by defining SERIAL_PARITY_TX_BUSY_EN.
module serial_parity_tx
    import serial_parity_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
`ifdef SERIAL_PARITY_TX_BUSY_EN
    output logic             busy,
`endif
    input  logic             out_ready
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             parity;
    logic             load;
    logic             shift;
    logic             par_clr;
    logic             par_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_bit   = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        par_clr   = 1'b0;
        par_en    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    par_clr = 1'b1;
                    nxt     = DATA;
                end
            end
            DATA: begin
                out_valid = 1'b1;
                out_bit   = shreg[0];
                if (out_ready) begin
                    shift  = 1'b1;
                    par_en = 1'b1;
                    if (cnt == LAST_IDX) begin
                        nxt = PARITY;
                    end
                end
            end
            PARITY: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_bit   = parity ^ (ODD_PARITY != 0);
                // Accepting the next word here lets frames run back-to-back.
                in_ready  = out_ready;
                if (out_ready) begin
                    par_clr = 1'b1;
                    if (in_valid) begin
                        load = 1'b1;
                        nxt  = DATA;
                    end else begin
                        nxt = IDLE;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= in_data;
            cnt   <= '0;
        end else if (shift) begin
            shreg <= shreg >> 1;
            // Hold on the final data beat so the counter never wraps.
            if (cnt != LAST_IDX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    parity_accum u_parity (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (par_clr),
        .en     (par_en),
        .bit_in (out_bit),
        .parity (parity)
    );

`ifdef SERIAL_PARITY_TX_BUSY_EN
    always_comb begin
        busy = (state != IDLE);
    end
`endif

endmodule

// File: tb/tb_serial_parity_tx.sv
// Scoreboard bench for serial_parity_tx: even and odd instances share stimulus.
module tb_serial_parity_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       in_ready, out_valid, out_bit, out_last;
    logic       in_ready_o, out_valid_o, out_bit_o, out_last_o;
`ifdef SERIAL_PARITY_TX_BUSY_EN
    logic       busy, busy_o;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned beats    = 0;
    logic [1:0]  exp_q[$];
    logic [1:0]  mon_e;

    always #5 clk = ~clk;

    serial_parity_tx #(.WIDTH(8), .ODD_PARITY(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last),
`ifdef SERIAL_PARITY_TX_BUSY_EN
        .busy      (busy),
`endif
        .out_ready (out_ready)
    );

    serial_parity_tx #(.WIDTH(8), .ODD_PARITY(1)) dut_odd (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_o),
        .in_data   (in_data),
        .out_valid (out_valid_o),
        .out_bit   (out_bit_o),
        .out_last  (out_last_o),
`ifdef SERIAL_PARITY_TX_BUSY_EN
        .busy      (busy_o),
`endif
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each beat entry is {bit, last}; the odd instance expects bit ^ last.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_bit", 32'(out_bit), 32'(mon_e[1]));
                check("out_last", 32'(out_last), 32'(mon_e[0]));
                check("odd_out_bit", 32'(out_bit_o), 32'(mon_e[1] ^ mon_e[0]));
                check("odd_out_last", 32'(out_last_o), 32'(mon_e[0]));
            end
        end
    end

    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({w[i], 1'b0});
        end
        exp_q.push_back({^w, 1'b1});
    endtask

    task automatic send_start(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        push_word(w);
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned b0;
        int unsigned cnt;
        bit          hs;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_bit", 32'(out_bit), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SERIAL_PARITY_TX_BUSY_EN
        check("rst_busy", 32'(busy), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // A5 even: first beat in the cycle after handshake, idle afterwards.
        b0 = beats;
        send_start(8'hA5);
        @(negedge clk);
        check("first_beat_valid", 32'(out_valid), 32'd1);
        drain();
        @(negedge clk);
        check("a5_beats", beats - b0, 32'd9);
        check("a5_ready_after", 32'(in_ready), 32'd1);
        check("a5_idle_valid", 32'(out_valid), 32'd0);
        check("a5_idle_last", 32'(out_last), 32'd0);
        @(posedge clk);
        #1;

        // 07: three ones, even parity 1 and odd parity 0.
        send_start(8'h07);
        drain();

        // A5 with a three-cycle stall on beat 2.
        b0 = beats;
        send_start(8'hA5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_bit", 32'(out_bit), 32'd1);
            check("stall_last", 32'(out_last), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        check("stall_beats", beats - b0, 32'd9);

        // Back-to-back 01 then FF with in_valid held.
        send_start(8'h01);
        push_word(8'hFF);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            if (out_valid) cnt++;
            else break;
            @(posedge clk);
            #1;
            if (hs) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("b2b_consecutive", cnt, 32'd18);
        drain();

        // Reset during beat 4 of 3C, then 80 sends cleanly.
        send_start(8'h3C);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_bit", 32'(out_bit), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        b0 = beats;
        send_start(8'h80);
        drain();
        check("post_rst_beats", beats - b0, 32'd9);

        // 00: nine active cycles, parity 0.
        send_start(8'h00);
        cnt = 0;
        b0  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
`ifdef SERIAL_PARITY_TX_BUSY_EN
            if (busy) b0++;
`endif
        end
        check("zero_valid_cycles", cnt, 32'd9);
`ifdef SERIAL_PARITY_TX_BUSY_EN
        check("zero_busy_cycles", b0, 32'd9);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_parity_tx.md
SERIAL_PARITY_TX -- requirements
Module: serial_parity_tx

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per word (>= 2).
REQ-002 Parameter ODD_PARITY, default 0, 0 = even parity bit, 1 = odd parity bit.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_data  input  WIDTH  parallel word; sampled only on handshake.
REQ-008 out_valid  output  1  out_bit is meaningful.
REQ-009 out_bit  output  1  current serial bit.
REQ-010 out_last  output  1  high on the parity beat, which is the final beat of a frame.
REQ-011 out_ready  input  1  downstream accepts the current beat.

Function
REQ-012 Input handshake SHALL occur when in_valid && in_ready; output beat SHALL transfer when out_valid && out_ready.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY.
REQ-014 IDLE: in_ready=1, out_valid=0; on input handshake, capture in_data into a shift register, clear the bit counter, go to DATA.
REQ-015 DATA: out_valid=1, out_bit=shift register bit 0, so data is sent LSB first; on output beat, shift right, increment the counter, and XOR the sent bit into the running parity.
REQ-016 DATA: after beat WIDTH-1 transfers, go to PARITY.
REQ-017 PARITY: out_valid=1, out_last=1, out_bit = XOR of all WIDTH data bits, inverted when ODD_PARITY=1.
REQ-018 PARITY: in_ready SHALL equal out_ready.
REQ-019 PARITY, output beat with no input handshake: go to IDLE.
REQ-020 PARITY, output beat with a simultaneous input handshake: load the new word, clear the parity and counter, go directly to DATA, so frames run back-to-back with no idle cycle.
REQ-021 in_ready SHALL be 0 in DATA.
REQ-022 Latency: the first data beat SHALL be presented in the cycle after the input handshake; one frame takes WIDTH+1 output beats.
REQ-023 While out_valid && !out_ready, out_bit, out_last and all internal state SHALL hold unchanged.
REQ-024 out_last SHALL be 0 in IDLE and DATA.
REQ-025 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap within a frame.

Reset
REQ-026 rst_n low SHALL immediately force the state to IDLE, shift register, counter and parity to 0, out_valid=0, out_last=0, out_bit=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release the block SHALL wait in IDLE with in_ready=1.

Configuration
REQ-028 Macro SERIAL_PARITY_TX_BUSY_EN: when defined, the block SHALL add output busy (1 bit), high in DATA and PARITY and 0 at reset.
REQ-029 Without SERIAL_PARITY_TX_BUSY_EN, the busy port SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-030 Package serial_parity_pkg SHALL hold the FSM state enum typedef (IDLE, DATA, PARITY) and the default WIDTH constant.
REQ-031 Sub-module parity_accum SHALL hold the running-parity flop with clear and enable inputs, XOR-ing the serial bit in on each enabled cycle.

Verification
REQ-032 WIDTH=8, even, out_ready=1, in_data=8'hA5 -> bits 1,0,1,0,0,1,0,1, then parity beat 0 with out_last=1; next cycle in_ready=1.
REQ-033 WIDTH=8, ODD_PARITY=1, in_data=8'h07 -> bits 1,1,1,0,0,0,0,0, then parity 0; with ODD_PARITY=0 the parity beat is 1.
REQ-034 8'hA5 with out_ready held low for 3 cycles on beat 2 -> out_bit=1 held for 3 cycles; the sequence resumes unchanged and totals 9 beats.
REQ-035 in_valid held high with words 8'h01, 8'hFF -> 18 consecutive out_valid beats; parity beats 1 then 0; no IDLE cycle between frames.
REQ-036 rst_n pulsed low during beat 4 of 8'h3C -> out_valid=0 at once; after release in_ready=1; a new word 8'h80 sends cleanly, with parity 1.
REQ-037 SERIAL_PARITY_TX_BUSY_EN defined, 8'h00 sent -> busy high for exactly 9 cycles with out_ready=1; parity beat 0.
